dac_sd_multi: RTL and testbench



---
 rtl/dac_sd_multi.sv | 170 +++++++++++++++++
 tb/tb_dac_sd_multi.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_sd_multi.sv
// ---------------------------------------------------------------------------
// dac_sd_multi
//
// Purpose:
//   Multi-channel 1-bit delta-sigma DAC. Each channel takes a signed PCM
//   sample and turns it into a 1-bit pulse-density stream. It uses an
//   error-feedback modulator whose order (first or second) can be changed
//   at run time.
//   The input is double-buffered: IN_VALID loads a holding register on any
//   clock edge, and each CLK_EN tick moves the holding register into the
//   active sample. The error state saturates instead of wrapping, and each
//   channel has its own sticky overflow flag.
//
// Ports:
//   CLK       system clock
//   RESET_n   asynchronous active-low reset
//   CLK_EN    modulator tick enable; all modulator state advances only here
//   IN_DATA   CH signed WIDTH-bit samples, channel c at [c*WIDTH +: WIDTH]
//   IN_VALID  load strobe into the holding registers (ignores CLK_EN)
//   MODE      0 = first order, 1 = second order
//   MUTE      1 = force the active sample of every channel to 0
//   OUT       registered 1-bit DAC outputs, one per channel
//   OVF       sticky per-channel error-saturation flags
//
// Parameters:
//   CH     number of channels (1..8)
//   WIDTH  signed sample width (4..16)
// ---------------------------------------------------------------------------
module dac_sd_multi #(
  parameter int CH    = 2,
  parameter int WIDTH = 10
) (
  input  logic                CLK,
  input  logic                RESET_n,
  input  logic                CLK_EN,
  input  logic [CH*WIDTH-1:0] IN_DATA,
  input  logic                IN_VALID,
  input  logic                MODE,
  input  logic                MUTE,
  output logic [CH-1:0]       OUT,
  output logic [CH-1:0]       OVF
);

  // Arithmetic width. The worst case for second order is |x| + 2|e1| + |e2| + H.
  // That is 14*H, so it stays below 2^(WIDTH+3) and WIDTH+4 bits are enough.
  localparam int AW = WIDTH + 4;
  // Stored error width. The clamp range is [-2^(WIDTH+1), 2^(WIDTH+1)-1].
  localparam int EW = WIDTH + 2;

  // Feedback magnitude H = 2^(WIDTH-1), i.e. full-scale of the input.
  localparam logic signed [AW-1:0] FB_MAG = AW'(2 ** (WIDTH - 1));

  // Saturation targets of the stored error state.
  localparam logic [EW-1:0] E_POS_SAT = {1'b0, {(EW-1){1'b1}}};
  localparam logic [EW-1:0] E_NEG_SAT = {1'b1, {(EW-1){1'b0}}};

  // -------------------------------------------------------------------------
  // Shared order register.
  // When MODE differs from the registered order on a tick, every channel
  // computes that tick with zeroed error history. This restarts the loop
  // cleanly, so the old order's state cannot kick the new loop into a pop.
  // -------------------------------------------------------------------------
  logic mode_reg;
  logic restart;

  assign restart = (MODE != mode_reg);

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      mode_reg <= 1'b0;
    end else if (CLK_EN) begin
      mode_reg <= MODE;
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel datapath. Channels are independent; they share only
  // CLK_EN, MODE, MUTE and the order register above.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      logic signed [WIDTH-1:0] in_hold_reg;
      logic signed [WIDTH-1:0] x_act_reg;
      logic signed [EW-1:0]    e1_reg;
      logic signed [EW-1:0]    e2_reg;
      logic                    out_reg;
      logic                    ovf_reg;

      logic signed [EW-1:0]    e1_eff;
      logic signed [EW-1:0]    e2_eff;
      logic signed [AW-1:0]    x_w;
      logic signed [AW-1:0]    e1_w;
      logic signed [AW-1:0]    e2_w;
      logic signed [AW-1:0]    v;
      logic signed [AW-1:0]    en_raw;
      logic signed [EW-1:0]    en_next;
      logic                    b;
      logic                    sat;

      // Error history as seen by this tick (zeroed on an order change).
      assign e1_eff = restart ? '0 : e1_reg;
      assign e2_eff = restart ? '0 : e2_reg;

      // Sign-extend everything into the common arithmetic width.
      assign x_w  = {{(AW-WIDTH){x_act_reg[WIDTH-1]}}, x_act_reg};
      assign e1_w = {{(AW-EW){e1_eff[EW-1]}}, e1_eff};
      assign e2_w = {{(AW-EW){e2_eff[EW-1]}}, e2_eff};

      // Loop filter input. Second order uses the noise shaping
      // (1 - z^-1)^2, which becomes 2*e1 - e2 in error-feedback form.
      always_comb begin
        v = x_w + e1_w;
        if (MODE) begin
          v = x_w + (e1_w <<< 1) - e2_w;
        end
      end

      // 1-bit quantiser: v >= 0 gives 1, and the feedback is +H or -H.
      assign b      = ~v[AW-1];
      assign en_raw = b ? (v - FB_MAG) : (v + FB_MAG);

      // en_raw fits the EW-bit error register only if its top AW-EW+1
      // bits are all copies of the sign. Any other pattern means it is out
      // of range, and the value is clamped toward its own sign.
      assign sat = ~((&en_raw[AW-1:EW-1]) | ~(|en_raw[AW-1:EW-1]));

      always_comb begin
        en_next = en_raw[EW-1:0];
        if (sat) begin
          en_next = en_raw[AW-1] ? E_NEG_SAT : E_POS_SAT;
        end
      end

      // Holding register: loads on any edge with IN_VALID, even between ticks.
      always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
          in_hold_reg <= '0;
        end else if (IN_VALID) begin
          in_hold_reg <= IN_DATA[gi*WIDTH +: WIDTH];
        end
      end

      // Modulator state. x_act_reg takes the holding register's value from
      // before this edge. A sample loaded on the same edge as a tick
      // therefore waits for the next tick.
      always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
          x_act_reg <= '0;
          e1_reg    <= '0;
          e2_reg    <= '0;
          out_reg   <= 1'b0;
          ovf_reg   <= 1'b0;
        end else if (CLK_EN) begin
          x_act_reg <= MUTE ? '0 : in_hold_reg;
          e2_reg    <= e1_eff;
          e1_reg    <= en_next;
          out_reg   <= b;
          if (sat) begin
            ovf_reg <= 1'b1;
          end
        end
      end

      assign OUT[gi] = out_reg;
      assign OVF[gi] = ovf_reg;
    end
  endgenerate

endmodule

// File: tb/tb_dac_sd_multi.sv
// ---------------------------------------------------------------------------
// tb_dac_sd_multi
//
// Purpose:
//   Self-checking bench for dac_sd_multi with CH=2 and WIDTH=10.
//   A hand-computed vector table covers the start-up sequence, the hold
//   behaviour, a coincident load, an order change and mute.
//   Longer sequences then check the densities and saturation against
//   constants, and check every cycle against a behavioural reference
//   model of the modulator.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_dac_sd_multi;

  logic        clk;
  logic        rst_n;
  logic        clk_en;
  logic [19:0] in_data;
  logic        in_valid;
  logic        mode;
  logic        mute;
  logic [1:0]  out_w;
  logic [1:0]  ovf_w;

  int errors = 0;
  int checks = 0;

  dac_sd_multi #(.CH(2), .WIDTH(10)) dut (
    .CLK      (clk),
    .RESET_n  (rst_n),
    .CLK_EN   (clk_en),
    .IN_DATA  (in_data),
    .IN_VALID (in_valid),
    .MODE     (mode),
    .MUTE     (mute),
    .OUT      (out_w),
    .OVF      (ovf_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s: got %0d required %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d required %0d..%0d", name, got, lo, hi);
    end
  endtask

  // ---------------- reference model ----------------
  int      d_cur [2];
  int      m_hold[2];
  int      m_xact[2];
  int      m_e1  [2];
  int      m_e2  [2];
  bit      m_mode;
  bit [1:0] m_out;
  bit [1:0] m_ovf;

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_hold[c] = 0; m_xact[c] = 0; m_e1[c] = 0; m_e2[c] = 0;
    end
    m_mode = 1'b0; m_out = 2'b00; m_ovf = 2'b00;
  endtask

  task automatic model_edge();
    int e1, e2, v, en;
    bit b;
    if (clk_en) begin
      for (int c = 0; c < 2; c++) begin
        e1 = (mode != m_mode) ? 0 : m_e1[c];
        e2 = (mode != m_mode) ? 0 : m_e2[c];
        if (mode) v = m_xact[c] + 2 * e1 - e2;
        else      v = m_xact[c] + e1;
        b  = (v >= 0);
        en = b ? v - 512 : v + 512;
        if (en > 2047) begin
          en = 2047; m_ovf[c] = 1'b1;
        end else if (en < -2048) begin
          en = -2048; m_ovf[c] = 1'b1;
        end
        m_e2[c]   = e1;
        m_e1[c]   = en;
        m_out[c]  = b;
        m_xact[c] = mute ? 0 : m_hold[c];
      end
      m_mode = mode;
    end
    if (in_valid) begin
      m_hold[0] = d_cur[0];
      m_hold[1] = d_cur[1];
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_data(input int a, input int b);
    d_cur[0] = a;
    d_cur[1] = b;
    in_data  = {10'(b), 10'(a)};
  endtask

  // One clock edge; the DUT is compared with the model 1 time unit later.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("out_vs_model", int'(out_w), int'(m_out));
    check("ovf_vs_model", int'(ovf_w), int'(m_ovf));
  endtask

  int ones[2];

  task automatic run(input int n, input int ws, input int we);
    for (int i = 1; i <= n; i++) begin
      step();
      if (i >= ws && i <= we) begin
        ones[0] += int'(out_w[0]);
        ones[1] += int'(out_w[1]);
      end
    end
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    clk_en   = 1'b0;
    mode     = 1'b0;
    mute     = 1'b0;
    set_data(0, 0);
    model_reset();
    #1;
    check("reset_out", int'(out_w), 0);
    check("reset_ovf", int'(ovf_w), 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Load a sample pair into the holding registers without a tick.
  task automatic load(input int a, input int b);
    set_data(a, b);
    in_valid = 1'b1;
    clk_en   = 1'b0;
    step();
    in_valid = 1'b0;
    clk_en   = 1'b1;
  endtask

  // ---------------- hand-computed vector table ----------------
  typedef struct packed {
    logic       valid;
    logic       en;
    logic       md;
    logic       mt;
    logic [9:0] d0;
    logic [9:0] d1;
    logic [1:0] exp_out;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(input bit v, input bit e, input bit md, input bit mt,
                              input int d0, input int d1, input bit [1:0] eo);
    vec_t r;
    r.valid = v; r.en = e; r.md = md; r.mt = mt;
    r.d0 = 10'(d0); r.d1 = 10'(d1); r.exp_out = eo;
    return r;
  endfunction

  logic [1:0] frz;
  int r0, r1;

  initial begin
    rst_n = 1'b0;
    // ch0 runs x=0, then x=+256 (loaded coincident with a tick), then
    // second order, then muted. ch1 runs x=-512 and is then muted.
    tbl[0]  = mk(1, 0, 0, 0, 0,   -512, 2'b00);
    tbl[1]  = mk(0, 1, 0, 0, 0,   0,    2'b11);
    tbl[2]  = mk(0, 1, 0, 0, 0,   0,    2'b00);
    tbl[3]  = mk(0, 1, 0, 0, 0,   0,    2'b01);
    tbl[4]  = mk(0, 0, 0, 0, 0,   0,    2'b01);  // CLK_EN low: hold
    tbl[5]  = mk(0, 1, 0, 0, 0,   0,    2'b00);
    tbl[6]  = mk(0, 1, 0, 0, 0,   0,    2'b01);
    tbl[7]  = mk(1, 1, 0, 0, 256, -512, 2'b00);  // load coincident with tick
    tbl[8]  = mk(0, 1, 0, 0, 0,   0,    2'b01);  // still old sample
    tbl[9]  = mk(0, 1, 0, 0, 0,   0,    2'b00);
    tbl[10] = mk(0, 1, 0, 0, 0,   0,    2'b01);
    tbl[11] = mk(0, 1, 0, 0, 0,   0,    2'b01);
    tbl[12] = mk(0, 1, 0, 0, 0,   0,    2'b01);
    tbl[13] = mk(0, 1, 0, 0, 0,   0,    2'b00);
    tbl[14] = mk(0, 1, 1, 0, 0,   0,    2'b01);  // order change: restart
    tbl[15] = mk(0, 1, 1, 0, 0,   0,    2'b00);
    tbl[16] = mk(0, 1, 1, 0, 0,   0,    2'b01);
    tbl[17] = mk(0, 1, 1, 0, 0,   0,    2'b01);
    tbl[18] = mk(0, 1, 1, 0, 0,   0,    2'b01);
    tbl[19] = mk(0, 1, 1, 0, 0,   0,    2'b01);
    tbl[20] = mk(0, 1, 1, 1, 0,   0,    2'b00);  // mute: x_act=0 next tick
    tbl[21] = mk(0, 1, 1, 1, 0,   0,    2'b11);
    tbl[22] = mk(0, 1, 1, 1, 0,   0,    2'b00);

    do_reset();
    for (int i = 0; i < 23; i++) begin
      in_valid = tbl[i].valid;
      clk_en   = tbl[i].en;
      mode     = tbl[i].md;
      mute     = tbl[i].mt;
      in_data  = {tbl[i].d1, tbl[i].d0};
      @(posedge clk);
      #1;
      $display("vec %0d: out=%b exp=%b ovf=%b", i, out_w, tbl[i].exp_out, ovf_w);
      check($sformatf("vec%0d_out", i), int'(out_w), int'(tbl[i].exp_out));
      check($sformatf("vec%0d_ovf", i), int'(ovf_w), 0);
    end

    // Idle input, first order: exact 1,0,1,0 from the first tick.
    do_reset();
    clk_en = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      step();
      check("alt_pattern", int'(out_w), (i % 2 == 1) ? 3 : 0);
    end
    $display("phase idle alternation done");

    // Negative full scale, first order: 0 from tick 2 onward.
    do_reset();
    load(-512, -512);
    for (int i = 1; i <= 300; i++) begin
      step();
      if (i >= 2) check("neg_fs_zero", int'(out_w), 0);
    end
    $display("phase negative full-scale done");

    // +511 first order: one 0 per 1024 ticks, no saturation.
    do_reset();
    load(511, 511);
    ones[0] = 0; ones[1] = 0;
    run(3072, 1025, 3072);
    check("pos_fs_zeros_ch0", 2048 - ones[0], 2);
    check("pos_fs_zeros_ch1", 2048 - ones[1], 2);
    check("pos_fs_ovf", int'(ovf_w), 0);
    $display("phase +511 first order done");

    // +256 second order: density 0.75 +/- 1/256 over 4096 ticks.
    do_reset();
    mode = 1'b1;
    load(256, 256);
    mode = 1'b1;
    ones[0] = 0; ones[1] = 0;
    run(4096, 1, 4096);
    check_range("so_density_ch0", ones[0], 3056, 3088);
    check_range("so_density_ch1", ones[1], 3056, 3088);
    check("so_ovf", int'(ovf_w), 0);
    $display("phase +256 second order done");

    // +511 second order: saturates, flag sticks, reset clears it.
    do_reset();
    mode = 1'b1;
    load(511, 511);
    mode = 1'b1;
    run(10000, 1, 0);
    check("sat_ovf_set", int'(ovf_w), 3);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_ovf", int'(ovf_w), 0);
    check("async_rst_out", int'(out_w), 0);
    @(negedge clk);
    rst_n = 1'b1;
    clk_en = 1'b0;
    step();
    check("post_rst_out", int'(out_w), 0);
    $display("phase saturation and reset done");

    // Mixed channels, first order: 0.625 and 0.375 densities.
    do_reset();
    load(128, -128);
    ones[0] = 0; ones[1] = 0;
    run(4096, 33, 4096);
    check_range("mix_density_ch0", ones[0], 2538, 2542);
    check_range("mix_density_ch1", ones[1], 1522, 1526);
    // Order toggles mid-stream, checked against the model.
    mode = 1'b1;
    run(100, 1, 0);
    mode = 1'b0;
    run(100, 1, 0);
    $display("phase mixed channels and order toggle done");

    // CLK_EN low for 50 cycles: OUT frozen while samples still load.
    frz = m_out;
    clk_en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      in_valid = (i % 3 == 0);
      r0 = int'($urandom_range(1023)) - 512;
      r1 = int'($urandom_range(1023)) - 512;
      set_data(r0, r1);
      step();
      check("frozen_out", int'(out_w), int'(frz));
    end
    in_valid = 1'b0;
    clk_en = 1'b1;
    run(50, 1, 0);
    $display("phase clock-enable freeze done");

    // Mixed random controls against the model.
    for (int i = 0; i < 800; i++) begin
      in_valid = ($urandom_range(3) == 0);
      clk_en   = ($urandom_range(2) != 0);
      if ($urandom_range(63) == 0) mode = ~mode;
      if ($urandom_range(31) == 0) mute = ~mute;
      r0 = int'($urandom_range(1023)) - 512;
      r1 = int'($urandom_range(1023)) - 512;
      set_data(r0, r1);
      step();
    end
    $display("phase random controls done");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
